// File: rtl/char_state_handler.sv
// Per-player action FSM: movement from button levels, fixed-length
// attack phases advanced on the game frame tick.
module char_state_handler #(
  parameter int unsigned START_FRAMES        = 5,
  parameter int unsigned ACTIVE_FRAMES       = 2,
  parameter int unsigned RECOVERY_FRAMES     = 16,
  parameter int unsigned DIR_START_FRAMES    = 4,
  parameter int unsigned DIR_ACTIVE_FRAMES   = 3,
  parameter int unsigned DIR_RECOVERY_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [3:0] state,
  output logic       attack_hit,
  output logic       busy,
  output logic [4:0] frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE                = 4'd0,
    S_LEFT                = 4'd1,
    S_RIGHT               = 4'd2,
    S_ATTACK_START        = 4'd3,
    S_ATTACK_ACTIVE       = 4'd4,
    S_ATTACK_RECOVERY     = 4'd5,
    S_ATTACK_DIR_START    = 4'd6,
    S_ATTACK_DIR_ACTIVE   = 4'd7,
    S_ATTACK_DIR_RECOVERY = 4'd8
  } state_t;

  localparam logic [4:0] ST_LEN  = 5'(START_FRAMES - 1);
  localparam logic [4:0] AC_LEN  = 5'(ACTIVE_FRAMES - 1);
  localparam logic [4:0] RC_LEN  = 5'(RECOVERY_FRAMES - 1);
  localparam logic [4:0] DST_LEN = 5'(DIR_START_FRAMES - 1);
  localparam logic [4:0] DAC_LEN = 5'(DIR_ACTIVE_FRAMES - 1);
  localparam logic [4:0] DRC_LEN = 5'(DIR_RECOVERY_FRAMES - 1);

  state_t     st_q, st_d;
  logic [4:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       prev_q;
  logic       rise, mov, dir;

  assign rise = btn_attack & ~prev_q;
  assign mov  = (st_q == S_IDLE) || (st_q == S_LEFT) ||
                (st_q == S_RIGHT);
  assign dir  = btn_left ^ btn_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      prev_q <= btn_attack;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    // a press seen this cycle only becomes usable on a later tick
    if (rise && mov) pend_d = 1'b1;
    if (frame_tick) begin
      if (mov) begin
        unique case (1'b1)
          pend_q && dir: begin
            st_d   = S_ATTACK_DIR_START;
            cnt_d  = DST_LEN;
            pend_d = 1'b0;
          end
          pend_q && !dir: begin
            st_d   = S_ATTACK_START;
            cnt_d  = ST_LEN;
            pend_d = 1'b0;
          end
          !pend_q && btn_left && !btn_right: begin
            st_d  = S_LEFT;
            cnt_d = '0;
          end
          !pend_q && btn_right && !btn_left: begin
            st_d  = S_RIGHT;
            cnt_d = '0;
          end
          default: begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end
        endcase
      end else if (cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end else begin
        unique case (st_q)
          S_ATTACK_START: begin
            st_d  = S_ATTACK_ACTIVE;
            cnt_d = AC_LEN;
          end
          S_ATTACK_ACTIVE: begin
            st_d  = S_ATTACK_RECOVERY;
            cnt_d = RC_LEN;
          end
          S_ATTACK_DIR_START: begin
            st_d  = S_ATTACK_DIR_ACTIVE;
            cnt_d = DAC_LEN;
          end
          S_ATTACK_DIR_ACTIVE: begin
            st_d  = S_ATTACK_DIR_RECOVERY;
            cnt_d = DRC_LEN;
          end
          default: begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end
  end

  assign state      = st_q;
  assign frame_cnt  = cnt_q;
  assign busy       = !mov;
  assign attack_hit = (st_q == S_ATTACK_ACTIVE) ||
                      (st_q == S_ATTACK_DIR_ACTIVE);

endmodule

// File: tb/tb_char_state_handler.sv
// Directed bench for char_state_handler: movement, both attack
// chains, discarded presses, same-cycle edge/tick, async reset.
module tb_char_state_handler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_attack;
  logic [3:0] state;
  logic       attack_hit;
  logic       busy;
  logic [4:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  char_state_handler dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_attack(btn_attack),
    .state(state),
    .attack_hit(attack_hit),
    .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] es,
                     input logic [4:0] ec);
    logic eb, eh;
    eb = (es >= 4'd3) && (es <= 4'd8);
    eh = (es == 4'd4) || (es == 4'd7);
    checks++;
    assert ({state, frame_cnt, busy, attack_hit} ===
            {es, ec, eb, eh})
    else begin
      failures++;
      $error("FAIL %s: state=%0d cnt=%0d busy=%0b hit=%0b required state=%0d cnt=%0d busy=%0b hit=%0b",
             tag, state, frame_cnt, busy, attack_hit, es, ec, eb, eh);
    end
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) btn_attack = 1'b1;
    @(negedge clk) btn_attack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_attack = 1'b0;
    idle(3);
    chk("reset", 4'd0, 5'd0);
    rst_n = 1'b1;
    idle(2);

    btn_left = 1'b1;
    tick();
    chk("left", 4'd1, 5'd0);
    idle(3);
    chk("left_hold", 4'd1, 5'd0);
    btn_right = 1'b1;
    tick();
    chk("both", 4'd0, 5'd0);
    btn_left = 1'b0;
    tick();
    chk("right", 4'd2, 5'd0);
    btn_left = 1'b1;
    btn_right = 1'b0;
    idle(4);
    chk("no_tick_hold", 4'd2, 5'd0);
    btn_left = 1'b0;
    tick();
    chk("release", 4'd0, 5'd0);

    press();
    idle(2);
    chk("pending_no_tick", 4'd0, 5'd0);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i <= 5)       chk("neutral", 4'd3, 5'(5 - i));
      else if (i <= 7)  chk("neutral", 4'd4, 5'(7 - i));
      else if (i <= 23) chk("neutral", 4'd5, 5'(23 - i));
      else              chk("neutral_end", 4'd0, 5'd0);
    end
    tick();
    chk("neutral_idle", 4'd0, 5'd0);

    btn_right = 1'b1;
    press();
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i <= 4)       chk("dir", 4'd6, 5'(4 - i));
      else if (i <= 7)  chk("dir", 4'd7, 5'(7 - i));
      else if (i <= 22) chk("dir", 4'd8, 5'(22 - i));
      else if (i == 23) chk("dir_end", 4'd0, 5'd0);
      else              chk("dir_move", 4'd2, 5'd0);
    end
    btn_right = 1'b0;
    tick();
    chk("dir_release", 4'd0, 5'd0);

    press();
    for (int i = 1; i <= 8; i++) tick();
    chk("rec_entry", 4'd5, 5'd15);
    press();
    @(negedge clk) btn_attack = 1'b1;
    for (int i = 9; i <= 24; i++) tick();
    chk("rec_done", 4'd0, 5'd0);
    tick();
    tick();
    chk("no_retrigger", 4'd0, 5'd0);
    btn_attack = 1'b0;
    idle(2);

    btn_left = 1'b1;
    tick();
    chk("sim_left", 4'd1, 5'd0);
    @(negedge clk) begin
      btn_attack = 1'b1;
      frame_tick = 1'b1;
    end
    @(negedge clk) frame_tick = 1'b0;
    chk("sim_same_tick", 4'd1, 5'd0);
    btn_attack = 1'b0;
    tick();
    chk("sim_next_tick", 4'd6, 5'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_reset", 4'd7, 5'd2);

    press();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 4'd0, 5'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("pending_lost", 4'd1, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
